// File: rtl/sseg_scan_driver.sv
// Time-multiplexed hex seven-segment scanner with per-digit dp, blanking and leading-zero suppression.
// Pins are registered: load -> pins after 2 edges, tick -> new digit on pins one edge later; no backpressure.
module sseg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_blank,
    input  logic                  load,
    output logic [6:0]            sseg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);

    localparam logic [6:0]        SEG_BLANK_RAW = 7'b1111111;
    localparam logic [6:0]        SEG_OFF       = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic              DP_OFF        = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] AN_OFF        = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Glyphs in active-low abcdefg form (a at bit 6).
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] value_sh_q, value_sh_d;
    logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [DIGITS-1:0]   blank_sh_q, blank_sh_d;
    logic                lz_sh_q, lz_sh_d;
    logic [6:0]          sseg_q, sseg_d;
    logic                dp_out_q, dp_out_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_done_q, frame_done_d;

    logic                tick;
    logic [DIGITS-1:0]   upper_zero;
    logic [DIGITS-1:0]   lz_sup;
    logic [DIGITS-1:0]   sel_onehot;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_blank;
    logic                cur_lz;
    logic [6:0]          seg_raw;
    logic                dp_lit;

    // Prescaler, digit index and shadow capture.
    always_comb begin
        tick       = (pre_q == PRE_LAST);
        pre_d      = tick ? '0 : pre_q + PRE_W'(1);
        idx_d      = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        value_sh_d = load ? value      : value_sh_q;
        dp_sh_d    = load ? dp         : dp_sh_q;
        blank_sh_d = load ? blank_mask : blank_sh_q;
        lz_sh_d    = load ? lz_blank   : lz_sh_q;
    end

    // upper_zero[k]: shadow digits k..DIGITS-1 are all zero.
    always_comb begin
        upper_zero             = '0;
        lz_sup                 = '0;
        upper_zero[DIGITS-1]   = (value_sh_q[4*(DIGITS-1) +: 4] == 4'h0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            upper_zero[k] = upper_zero[k+1] && (value_sh_q[4*k +: 4] == 4'h0);
        end
        for (int k = 1; k < DIGITS; k++) begin
            lz_sup[k] = lz_sh_q && upper_zero[k];
        end
    end

    // Select the digit currently addressed by idx.
    always_comb begin
        sel_onehot = '0;
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_lz     = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_onehot[k] = 1'b1;
                cur_nib       = value_sh_q[4*k +: 4];
                cur_dp        = dp_sh_q[k];
                cur_blank     = blank_sh_q[k];
                cur_lz        = lz_sup[k];
            end
        end
    end

    // Blank mask beats suppression; a suppressed digit keeps its dp.
    always_comb begin
        seg_raw = hex_glyph(cur_nib);
        dp_lit  = cur_dp;
        if (cur_blank) begin
            seg_raw = SEG_BLANK_RAW;
            dp_lit  = 1'b0;
        end else if (cur_lz) begin
            seg_raw = SEG_BLANK_RAW;
        end
        sseg_d       = SEG_ACTIVE_LOW ? seg_raw : ~seg_raw;
        dp_out_d     = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
        an_d         = AN_ACTIVE_LOW ? ~sel_onehot : sel_onehot;
        frame_done_d = tick && (idx_q == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q        <= '0;
            idx_q        <= '0;
            value_sh_q   <= '0;
            dp_sh_q      <= '0;
            blank_sh_q   <= '0;
            lz_sh_q      <= 1'b0;
            sseg_q       <= SEG_OFF;
            dp_out_q     <= DP_OFF;
            an_q         <= AN_OFF;
            frame_done_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            value_sh_q   <= value_sh_d;
            dp_sh_q      <= dp_sh_d;
            blank_sh_q   <= blank_sh_d;
            lz_sh_q      <= lz_sh_d;
            sseg_q       <= sseg_d;
            dp_out_q     <= dp_out_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sseg       = sseg_q;
    assign dp_out     = dp_out_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed-vector bench: main 4-digit instance, an inverted-polarity twin and a 1-digit/CLK_DIV=1 instance.
module tb_sseg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank_mask;
    logic        lz_blank;
    logic        load;

    logic [6:0]  sseg,  sseg_p,  sseg_1;
    logic        dp_out, dp_out_p, dp_out_1;
    logic [3:0]  an, an_p;
    logic [0:0]  an_1;
    logic        fd, fd_p, fd_1;

    int n_cmp;
    int n_bad;
    int cyc;

    sseg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .blank_mask(blank_mask),
        .lz_blank(lz_blank), .load(load), .sseg(sseg), .dp_out(dp_out), .an(an), .frame_done(fd)
    );

    sseg_scan_driver #(.DIGITS(4), .CLK_DIV(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_p (
        .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .blank_mask(blank_mask),
        .lz_blank(lz_blank), .load(load), .sseg(sseg_p), .dp_out(dp_out_p), .an(an_p), .frame_done(fd_p)
    );

    sseg_scan_driver #(.DIGITS(1), .CLK_DIV(1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_1 (
        .clk(clk), .rst_n(rst_n), .value(value[3:0]), .dp(dp[0:0]), .blank_mask(blank_mask[0:0]),
        .lz_blank(lz_blank), .load(load), .sseg(sseg_1), .dp_out(dp_out_1), .an(an_1), .frame_done(fd_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
        int          digit;
        logic [6:0]  exp_seg;
        logic        exp_dp;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cyc %0d): got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic apply_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b, input logic l);
        value      = v;
        dp         = d;
        blank_mask = b;
        lz_blank   = l;
        load       = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
    endtask

    task automatic wait_digit(input int k);
        logic [3:0] exp_an;
        exp_an = ~(4'b0001 << k);
        for (int i = 0; i < 20; i++) begin
            if (an === exp_an) break;
            step();
        end
        check("wait_an", {28'd0, an}, {28'd0, exp_an});
    endtask

    initial begin
        logic [6:0] g_f3a9[4];
        logic [3:0] e_an;
        int         d;

        n_cmp = 0; n_bad = 0; cyc = 0;
        rst_n = 1'b0; load = 1'b0; value = '0; dp = '0; blank_mask = '0; lz_blank = 1'b0;

        g_f3a9[0] = 7'b0000100; g_f3a9[1] = 7'b0001000;
        g_f3a9[2] = 7'b0000110; g_f3a9[3] = 7'b0111000;

        vecs[0]  = '{16'h0005, 4'b0010, 4'b0000, 1'b1, 3, 7'b1111111, 1'b1};
        vecs[1]  = '{16'h0005, 4'b0010, 4'b0000, 1'b1, 2, 7'b1111111, 1'b1};
        vecs[2]  = '{16'h0005, 4'b0010, 4'b0000, 1'b1, 1, 7'b1111111, 1'b0};
        vecs[3]  = '{16'h0005, 4'b0010, 4'b0000, 1'b1, 0, 7'b0100100, 1'b1};
        vecs[4]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 0, 7'b0000001, 1'b1};
        vecs[5]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 1, 7'b1111111, 1'b1};
        vecs[6]  = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 3, 7'b1111111, 1'b1};
        vecs[7]  = '{16'h1234, 4'b0100, 4'b0100, 1'b0, 2, 7'b1111111, 1'b1};
        vecs[8]  = '{16'h1234, 4'b0100, 4'b0100, 1'b0, 3, 7'b1001111, 1'b1};
        vecs[9]  = '{16'h1234, 4'b0100, 4'b0100, 1'b0, 1, 7'b0000110, 1'b1};
        vecs[10] = '{16'h1234, 4'b0100, 4'b0100, 1'b0, 0, 7'b1001100, 1'b1};
        vecs[11] = '{16'h0567, 4'b0000, 4'b0000, 1'b1, 3, 7'b1111111, 1'b1};
        vecs[12] = '{16'h0567, 4'b0000, 4'b0000, 1'b1, 2, 7'b0100100, 1'b1};
        vecs[13] = '{16'hBCDE, 4'b0000, 4'b0000, 1'b0, 0, 7'b0110000, 1'b1};
        vecs[14] = '{16'hBCDE, 4'b0000, 4'b0000, 1'b0, 1, 7'b1000010, 1'b1};
        vecs[15] = '{16'hBCDE, 4'b0000, 4'b0000, 1'b0, 2, 7'b0110001, 1'b1};
        vecs[16] = '{16'hBCDE, 4'b0000, 4'b0000, 1'b0, 3, 7'b1100000, 1'b1};
        vecs[17] = '{16'h6802, 4'b0000, 4'b0000, 1'b1, 1, 7'b0000001, 1'b1};
        vecs[18] = '{16'h6802, 4'b0000, 4'b0000, 1'b1, 3, 7'b0100000, 1'b1};
        vecs[19] = '{16'h1111, 4'b1111, 4'b0000, 1'b0, 0, 7'b1001111, 1'b0};

        // Reset levels for all three polarity/size variants.
        step(); step();
        check("rst_sseg", {25'd0, sseg}, {25'd0, 7'b1111111});
        check("rst_an",   {28'd0, an},   {28'd0, 4'b1111});
        check("rst_dp",   {31'd0, dp_out}, 32'd1);
        check("rst_fd",   {31'd0, fd},   32'd0);
        check("rst_p_sseg", {25'd0, sseg_p}, 32'd0);
        check("rst_p_an",   {28'd0, an_p},   32'd0);
        check("rst_p_dp",   {31'd0, dp_out_p}, 32'd0);
        check("rst_1_an",   {31'd0, an_1},   32'd0);
        check("rst_1_fd",   {31'd0, fd_1},   32'd0);

        // Release with a load on the very first edge; that edge still shows the reset shadow.
        rst_n = 1'b1;
        cyc   = 0;
        value = 16'hF3A9;
        load  = 1'b1;
        step();
        load = 1'b0;
        check("first_an",   {28'd0, an},   {28'd0, 4'b1110});
        check("first_sseg", {25'd0, sseg}, {25'd0, 7'b0000001});
        check("first_dp",   {31'd0, dp_out}, 32'd1);

        // Full scan: pins after edge c show digit ((c-1)/4)%4; frame_done after every 16th edge.
        for (int c = 2; c <= 33; c++) begin
            step();
            d    = ((c - 1) / 4) % 4;
            e_an = ~(4'b0001 << d);
            check("scan_an",   {28'd0, an},   {28'd0, e_an});
            check("scan_sseg", {25'd0, sseg}, {25'd0, g_f3a9[d]});
            check("scan_fd",   {31'd0, fd},   {31'd0, (c % 16) == 0});
            check("deg_an",    {31'd0, an_1}, 32'd1);
            check("deg_fd",    {31'd0, fd_1}, 32'd1);
        end

        // Load coinciding with the tick edge (edge 36).
        while (cyc < 35) step();
        value = 16'h7777;
        load  = 1'b1;
        step();
        load = 1'b0;
        check("coll_old_an",   {28'd0, an},   {28'd0, 4'b1110});
        check("coll_old_sseg", {25'd0, sseg}, {25'd0, 7'b0000100});
        step();
        check("coll_new_an",   {28'd0, an},   {28'd0, 4'b1101});
        check("coll_new_sseg", {25'd0, sseg}, {25'd0, 7'b0001111});

        // Asynchronous reset in the middle of a clock phase.
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sseg", {25'd0, sseg}, {25'd0, 7'b1111111});
        check("mid_rst_an",   {28'd0, an},   {28'd0, 4'b1111});
        check("mid_rst_dp",   {31'd0, dp_out}, 32'd1);
        check("mid_rst_fd",   {31'd0, fd},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rerel_an",   {28'd0, an},   {28'd0, 4'b1110});
        check("rerel_sseg", {25'd0, sseg}, {25'd0, 7'b0000001});

        for (int i = 0; i < NVEC; i++) begin
            apply_load(vecs[i].value, vecs[i].dp, vecs[i].blank, vecs[i].lz);
            wait_digit(vecs[i].digit);
            check("vec_sseg", {25'd0, sseg},   {25'd0, vecs[i].exp_seg});
            check("vec_dp",   {31'd0, dp_out}, {31'd0, vecs[i].exp_dp});
        end

        // Inputs change without load: the display must keep the last loaded frame.
        value = 16'hFFFF;
        dp    = 4'b0000;
        for (int i = 0; i < 20; i++) step();
        wait_digit(0);
        check("hold_sseg", {25'd0, sseg},   {25'd0, 7'b1001111});
        check("hold_dp",   {31'd0, dp_out}, 32'd0);

        // Inverted polarity twin showing glyph 8.
        apply_load(16'h8888, 4'b0000, 4'b0000, 1'b0);
        wait_digit(2);
        check("pol_sseg", {25'd0, sseg_p}, {25'd0, 7'b1111111});
        check("pol_an",   {28'd0, an_p},   {28'd0, 4'b0100});
        check("pol_dp",   {31'd0, dp_out_p}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
